alu_control_md: RTL
===================

Name: alu_control_md

Overview:
- Parametrised successor of the single-cycle ALU control decoder.
- Decodes alu_op/func7/func3 into the 4-bit ALU control code for single-cycle ops, as before.
- Adds an iterative multiply/divide sequencer for the RV32M-style funct7=0000001 group, with a pipeline stall handshake.
- Sits in the EX stage beside the ALU; the EX result mux selects md_result when alu_control=MD_OP.

Parameters:
- DATA_W, 32, operand/result width; iteration count of the sequencer.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous active-high reset
- func7  in  7  instruction funct7
- func3  in  3  instruction funct3
- alu_op  in  2  00 add, 01 sub, 10 R-type, 11 reserved
- ex_valid  in  1  EX stage holds a valid instruction
- flush  in  1  squash the EX instruction; abort any running operation
- op_a  in  DATA_W  rs1 value
- op_b  in  DATA_W  rs2 value
- alu_control  out  4  combinational ALU code
- stall  out  1  hold IF/ID/EX pipeline registers
- md_done  out  1  one-cycle pulse: md_result valid
- md_result  out  DATA_W  multiply/divide result

Behaviour:
- Reset value of every output is 0, except alu_control, which is combinational.
- alu_control codes: AND 0, OR 1, ADD 2, SLL 3, SRL 4, SUB 6, SLT 7, MD_OP 8.
- alu_op=00 -> 2. alu_op=01 -> 6. alu_op=11 -> 0.
- alu_op=10 with func7=0000000: func3 000 ADD, 111 AND, 110 OR, 010 SLT, 001 SLL, 101 SRL.
- alu_op=10 with func7=0100000 and func3=000 -> SUB.
- alu_op=10 with func7=0000001 and a supported func3 -> MD_OP.
- Any other alu_op=10 combination -> 0 (AND).
- Supported M ops (unsigned base): func3 000 MUL (low word), 011 MULHU (high word), 101 DIVU, 111 REMU.
- md_req = ex_valid & ~flush & alu_control==MD_OP.
- FSM states: IDLE, RUN, DONE.
- IDLE: on md_req, latch operands and func3; cnt=0; go to RUN. stall=1 combinationally in this cycle (cycle 0).
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*DATA_W product register.
  - Divide: restoring, 1 quotient bit per cycle.
  - cnt increments each cycle. After DATA_W RUN cycles (cycles 1..DATA_W), go to DONE. stall=1 throughout.
- DONE (cycle DATA_W+1): md_done=1, md_result registered, stall=0, so the pipeline advances. Next state is IDLE.
- The same instruction is still present in EX during DONE; the sequencer does not restart on it in that cycle.
- Latency: result available DATA_W+1 cycles after the request cycle. Back-to-back M ops: the next op is accepted in IDLE, i.e. the cycle after DONE.
- Divide by zero: no trap, takes full latency. DIVU returns all ones; REMU returns op_a.
- flush in RUN or DONE: return to IDLE next cycle; md_done stays 0; stall drops to 0 in the flush cycle.
- arst at any time returns immediately to IDLE and clears the counter, the datapath registers and all outputs.
- md_result holds its last value until the next DONE.

Optional Feature:
- Macro: ALU_CONTROL_MD_SIGNED_EN.
- Defined: also decode func3 001 MULH, 010 MULHSU, 100 DIV, 110 REM.
  - Operands are converted to magnitudes at entry; sign is corrected in DONE (one extra RUN cycle allowed: latency DATA_W+2 for signed ops only).
  - DIV of most-negative by -1 returns most-negative; REM of that case returns 0.
  - DIV by 0 returns -1; REM by 0 returns op_a.
- Undefined: those func3 codes decode to 0 (AND) and never start the sequencer.

Decomposition:
- Package alu_control_pkg: the alu_op codes, the ALU control codes (including MD_OP), funct7 constants (BASE, ALT, MULDIV), M-group func3 constants, and the FSM state enum.
- One sub-module, md_iter_core: the iterative multiply/divide datapath (start, op, operands -> done, result).
- alu_control_md holds the decode and the FSM/handshake.

Test Plan:
- Decode sweep: alu_op=10, func7=0100000, func3=000 -> alu_control=6. func7=0000000, func3=101 -> 4. alu_op=11 -> 0. stall stays 0 throughout.
- MUL 7*6, DATA_W=32: stall=1 in cycles 0..32, md_done=1 at cycle 33 with md_result=42.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MUL of the same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- flush at cycle 10 of a DIVU: stall=0 in cycle 10, no md_done pulse. A new MUL 3*3 in the next cycle -> 9 after full latency.
- arst asserted mid-RUN: stall, md_done and md_result are 0 immediately. After release, MULHU 2^31*4 -> 2.

Source files
------------

// File: rtl/alu_control_pkg.sv
// Shared codes for the ALU control decoder and the multiply/divide sequencer.
// Build option: define ALU_CONTROL_MD_SIGNED_EN to enable signed M-group ops.
package alu_control_pkg;

`ifdef ALU_CONTROL_MD_SIGNED_EN
   localparam bit SignedEn = 1'b1;
`else
   localparam bit SignedEn = 1'b0;
`endif

   // alu_op encodings from the main decoder
   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpRtype = 2'b10;
   localparam logic [1:0] AluOpRsvd  = 2'b11;

   // ALU control codes; AluMdOp steers the EX result mux to md_result
   typedef enum logic [3:0] {
      AluAnd  = 4'd0,
      AluOr   = 4'd1,
      AluAdd  = 4'd2,
      AluSll  = 4'd3,
      AluSrl  = 4'd4,
      AluSub  = 4'd6,
      AluSlt  = 4'd7,
      AluMdOp = 4'd8
   } alu_ctrl_e;

   localparam logic [6:0] F7Base   = 7'b0000000;
   localparam logic [6:0] F7Alt    = 7'b0100000;
   localparam logic [6:0] F7MulDiv = 7'b0000001;

   // M-group func3
   localparam logic [2:0] F3Mul    = 3'b000;
   localparam logic [2:0] F3Mulh   = 3'b001;
   localparam logic [2:0] F3Mulhsu = 3'b010;
   localparam logic [2:0] F3Mulhu  = 3'b011;
   localparam logic [2:0] F3Div    = 3'b100;
   localparam logic [2:0] F3Divu   = 3'b101;
   localparam logic [2:0] F3Rem    = 3'b110;
   localparam logic [2:0] F3Remu   = 3'b111;

   typedef enum logic [1:0] {StIdle, StRun, StDone} md_state_e;

   function automatic logic md_supported(input logic [2:0] f3);
      return SignedEn || (f3 inside {F3Mul, F3Mulhu, F3Divu, F3Remu});
   endfunction

   // rs1 treated as signed
   function automatic logic md_signed_a(input logic [2:0] f3);
      return SignedEn && (f3 inside {F3Mulh, F3Mulhsu, F3Div, F3Rem});
   endfunction

   // rs2 treated as signed
   function automatic logic md_signed_b(input logic [2:0] f3);
      return SignedEn && (f3 inside {F3Mulh, F3Div, F3Rem});
   endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 iterative multiply/divide datapath. Multiply is shift-add into {acc, lo};
// divide is restoring with remainder in acc and quotient shifting into lo.
module md_iter_core
   import alu_control_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              start,
   input  logic              step,
   input  logic              last,
   input  logic              fix,
   input  logic [2:0]        func3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              signed_op,
   output logic [DATA_W-1:0] result
);

   logic [2:0]        f3_q;
   logic              neg_q, signed_q;
   logic [DATA_W-1:0] opnd_q, acc_q, lo_q, result_q;
   logic [DATA_W-1:0] acc_d, lo_d, result_d, mag_a, mag_b;
   logic [DATA_W:0]   mul_sum, div_sh, div_diff;
   logic              sa, sb, neg_start;

   // Selects the requested word and applies the deferred sign correction
   function automatic logic [DATA_W-1:0] pick(input logic [2:0] f3, input logic neg,
                                              input logic [DATA_W-1:0] hi,
                                              input logic [DATA_W-1:0] lo);
      logic [2*DATA_W-1:0] full;
      logic [DATA_W-1:0]   word;
      full = {hi, lo};
      if (neg) full = -full;
      word = f3[1] ? hi : lo;
      if (!f3[2]) return (f3 == F3Mul) ? full[DATA_W-1:0] : full[2*DATA_W-1:DATA_W];
      return neg ? -word : word;
   endfunction

   // Entry magnitudes, one iteration step and the result to capture
   always_comb begin
      sa    = md_signed_a(func3) & op_a[DATA_W-1];
      sb    = md_signed_b(func3) & op_b[DATA_W-1];
      mag_a = sa ? -op_a : op_a;
      mag_b = sb ? -op_b : op_b;
      // Quotient by zero stays all ones; remainder sign follows the dividend
      if (!func3[2])    neg_start = sa ^ sb;
      else if (func3[1]) neg_start = sa;
      else               neg_start = (sa ^ sb) & (|op_b);

      mul_sum  = {1'b0, acc_q} + ({1'b0, opnd_q} & {(DATA_W+1){lo_q[0]}});
      div_sh   = {acc_q, lo_q[DATA_W-1]};
      div_diff = div_sh - {1'b0, opnd_q};

      acc_d = acc_q;
      lo_d  = lo_q;
      if (!f3_q[2]) begin
         acc_d = mul_sum[DATA_W:1];
         lo_d  = {mul_sum[0], lo_q[DATA_W-1:1]};
      end else if (!div_diff[DATA_W]) begin
         acc_d = div_diff[DATA_W-1:0];
         lo_d  = {lo_q[DATA_W-2:0], 1'b1};
      end else begin
         acc_d = div_sh[DATA_W-1:0];
         lo_d  = {lo_q[DATA_W-2:0], 1'b0};
      end

      result_d = result_q;
      if (step && last && !signed_q) result_d = pick(f3_q, neg_q, acc_d, lo_d);
      else if (fix)                  result_d = pick(f3_q, neg_q, acc_q, lo_q);
   end

   // Operand latch, iteration registers and result hold
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         f3_q     <= '0;
         neg_q    <= 1'b0;
         signed_q <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         if (start) begin
            f3_q     <= func3;
            neg_q    <= neg_start;
            signed_q <= md_signed_a(func3);
            acc_q    <= '0;
            opnd_q   <= func3[2] ? mag_b : mag_a;
            lo_q     <= func3[2] ? mag_a : mag_b;
         end else if (step) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
         end
         result_q <= result_d;
      end
   end

   assign signed_op = signed_q;
   assign result    = result_q;

endmodule

// File: rtl/alu_control_md.sv
// ALU control decoder with an iterative multiply/divide sequencer and stall handshake.
// Build option: define ALU_CONTROL_MD_SIGNED_EN to enable MULH/MULHSU/DIV/REM.
module alu_control_md
   import alu_control_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              arst,
   input  logic [6:0]        func7,
   input  logic [2:0]        func3,
   input  logic [1:0]        alu_op,
   input  logic              ex_valid,
   input  logic              flush,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [3:0]        alu_control,
   output logic              stall,
   output logic              md_done,
   output logic [DATA_W-1:0] md_result
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CntFix  = CNT_W'(DATA_W);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_req, start, step, last, fix, signed_op;

   // Single-cycle ALU code decode
   always_comb begin
      alu_control = AluAnd;
      unique case (alu_op)
         AluOpAdd:  alu_control = AluAdd;
         AluOpSub:  alu_control = AluSub;
         AluOpRsvd: alu_control = AluAnd;
         AluOpRtype: begin
            if (func7 == F7Base) begin
               case (func3)
                  3'b000:  alu_control = AluAdd;
                  3'b111:  alu_control = AluAnd;
                  3'b110:  alu_control = AluOr;
                  3'b010:  alu_control = AluSlt;
                  3'b001:  alu_control = AluSll;
                  3'b101:  alu_control = AluSrl;
                  default: alu_control = AluAnd;
               endcase
            end else if (func7 == F7Alt && func3 == 3'b000) begin
               alu_control = AluSub;
            end else if (func7 == F7MulDiv && md_supported(func3)) begin
               alu_control = AluMdOp;
            end
         end
         default: alu_control = AluAnd;
      endcase
   end

   assign md_req = ex_valid & ~flush & (alu_control == AluMdOp);

   // Sequencer next state and handshake; arst masks stall while asserted
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      md_done = 1'b0;
      start   = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      last    = (cnt_q == CntLast);
      unique case (state_q)
         StIdle: begin
            if (md_req && !arst) begin
               stall   = 1'b1;
               start   = 1'b1;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q < CntFix) step = 1'b1;
               else                fix  = 1'b1;
               if (cnt_q == (signed_op ? CntFix : CntLast)) state_d = StDone;
            end
         end
         StDone: begin
            // The instruction is still in EX here; go idle rather than restart on it
            md_done = ~flush;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   md_iter_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .clk       (clk),
      .arst      (arst),
      .start     (start),
      .step      (step),
      .last      (last),
      .fix       (fix),
      .func3     (func3),
      .op_a      (op_a),
      .op_b      (op_b),
      .signed_op (signed_op),
      .result    (md_result)
   );

endmodule
